matrix_mult_ctrl: RTL and testbench

Command-driven sequencer for the 5×5 signed 8-bit matrix-multiply datapath.
- Holds the A and B operand registers and loads them one row per command.
- Launches the multiplier, waits for its done pulse with a timeout, and captures the 200-bit result.
- Serves result rows back to the host.
- Sits between the host bus bridge (HPS/FIFO side) and the multiplier core; it is the only block that drives the multiplier inputs.

---
 rtl/matrix_mult_ctrl.sv | 168 ++++++++++++++++
 tb/tb_matrix_mult_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mult_ctrl.sv
// Command sequencer for the 5x5 matrix-multiply datapath: owns the A/B operand
// registers, launches the multiplier with a done timeout, and serves C rows.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | ready for a host command
// EXEC      | one-cycle execute of the latched command (loads, read, launch)
// WAIT_MULT | waiting for mult_done, timeout down-counter running
// RESP      | response presented until the host takes it
module matrix_mult_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [2:0]   cmd_row,
   input  logic [39:0]  cmd_data,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [39:0]  rsp_data,
   output logic         rsp_error,
   output logic [199:0] matriz_a,
   output logic [199:0] matriz_b,
   output logic         mult_start,
   input  logic         mult_done,
   input  logic [199:0] mult_c
);

   typedef enum logic [1:0] {IDLE, EXEC, WAIT_MULT, RESP} state_t;

   localparam logic [1:0] OP_LOAD_A   = 2'b00;
   localparam logic [1:0] OP_LOAD_B   = 2'b01;
   localparam logic [1:0] OP_MULTIPLY = 2'b10;
   localparam logic [1:0] OP_READ_C   = 2'b11;

   // Loaded in EXEC so the terminal count lands exactly TIMEOUT cycles into WAIT_MULT.
   localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);

   state_t         state_q, state_d;
   logic [1:0]     op_q;
   logic [2:0]     row_q;
   logic [39:0]    data_q;
   logic [199:0]   a_q, b_q, c_q;
   logic           c_valid_q;
   logic [7:0]     tmo_q;
   logic [39:0]    rsp_data_q;
   logic           rsp_error_q;

   logic           row_ok;
   logic           tmo_done;
   logic [39:0]    c_row;

   assign row_ok   = (row_q <= 3'd4);
   assign tmo_done = (tmo_q == 8'd0);

   always_comb begin
      c_row = '0;
      for (int r = 0; r < 5; r++) begin
         if (row_q == 3'(r)) c_row = c_q[r*40 +: 40];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (cmd_valid) state_d = EXEC;
         EXEC:      state_d = (op_q == OP_MULTIPLY) ? WAIT_MULT : RESP;
         WAIT_MULT: if (mult_done || tmo_done) state_d = RESP;
         RESP:      if (rsp_ready) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready  = 1'b0;
      rsp_valid  = 1'b0;
      mult_start = 1'b0;
      case (state_q)
         IDLE:    cmd_ready  = 1'b1;
         EXEC:    mult_start = (op_q == OP_MULTIPLY);
         RESP:    rsp_valid  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         op_q        <= '0;
         row_q       <= '0;
         data_q      <= '0;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         c_valid_q   <= 1'b0;
         tmo_q       <= '0;
         rsp_data_q  <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  op_q   <= cmd_op;
                  row_q  <= cmd_row;
                  data_q <= cmd_data;
               end
            end
            EXEC: begin
               rsp_data_q  <= '0;
               rsp_error_q <= 1'b0;
               case (op_q)
                  OP_LOAD_A: begin
                     if (row_ok) begin
                        for (int r = 0; r < 5; r++)
                           if (row_q == 3'(r)) a_q[r*40 +: 40] <= data_q;
                        c_valid_q <= 1'b0;
                     end else begin
                        rsp_error_q <= 1'b1;
                     end
                  end
                  OP_LOAD_B: begin
                     if (row_ok) begin
                        for (int r = 0; r < 5; r++)
                           if (row_q == 3'(r)) b_q[r*40 +: 40] <= data_q;
                        c_valid_q <= 1'b0;
                     end else begin
                        rsp_error_q <= 1'b1;
                     end
                  end
                  OP_READ_C: begin
                     if (row_ok && c_valid_q) rsp_data_q  <= c_row;
                     else                     rsp_error_q <= 1'b1;
                  end
                  OP_MULTIPLY: begin
                     // C from a previous run is stale once a new product is requested.
                     c_valid_q <= 1'b0;
                     tmo_q     <= TMO_LOAD;
                  end
               endcase
            end
            WAIT_MULT: begin
               if (mult_done) begin
                  c_q         <= mult_c;
                  c_valid_q   <= 1'b1;
                  rsp_error_q <= 1'b0;
               end else if (tmo_done) begin
                  rsp_error_q <= 1'b1;
               end else begin
                  tmo_q <= tmo_q - 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign matriz_a  = a_q;
   assign matriz_b  = b_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_matrix_mult_ctrl.sv
// Directed bench for matrix_mult_ctrl: table of command vectors with hand-computed
// responses/latencies, plus sequences for reset, backpressure and spurious done.
module tb_matrix_mult_ctrl;

   localparam int TMO = 16;
   localparam logic [1:0] LA = 2'b00;
   localparam logic [1:0] LB = 2'b01;
   localparam logic [1:0] MU = 2'b10;
   localparam logic [1:0] RC = 2'b11;

   logic         clock;
   logic         reset_n;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [2:0]   cmd_row;
   logic [39:0]  cmd_data;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [39:0]  rsp_data;
   logic         rsp_error;
   logic [199:0] matriz_a;
   logic [199:0] matriz_b;
   logic         mult_start;
   logic         mult_done;
   logic [199:0] mult_c;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int start_cnt = 0;

   matrix_mult_ctrl #(.TIMEOUT(TMO)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_row    (cmd_row),
      .cmd_data   (cmd_data),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_error  (rsp_error),
      .matriz_a   (matriz_a),
      .matriz_b   (matriz_b),
      .mult_start (mult_start),
      .mult_done  (mult_done),
      .mult_c     (mult_c)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) if (mult_start === 1'b1) start_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
      $fatal(1);
   end

   typedef struct {
      logic [1:0]   op;
      logic [2:0]   row;
      logic [39:0]  data;
      int           done_at;
      logic [199:0] c;
      logic         exp_err;
      logic [39:0]  exp_rd;
      int           exp_lat;
   } vec_t;

   vec_t vecs[20];

   function automatic vec_t mk(input logic [1:0] op, input logic [2:0] row, input logic [39:0] data,
                               input int done_at, input logic [199:0] c, input logic exp_err,
                               input logic [39:0] exp_rd, input int exp_lat);
      vec_t v;
      v.op = op; v.row = row; v.data = data; v.done_at = done_at; v.c = c;
      v.exp_err = exp_err; v.exp_rd = exp_rd; v.exp_lat = exp_lat;
      return v;
   endfunction

   task automatic check_vec(input string name, input logic [199:0] act, input logic [199:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Called #1 after a rising edge with the DUT idle. lat counts edges from the
   // accept edge to the one after which rsp_valid is seen.
   task automatic run_cmd(input logic [1:0] op, input logic [2:0] row, input logic [39:0] data,
                          input int done_at, input logic [199:0] c,
                          output logic err, output logic [39:0] rd, output int lat,
                          output logic start_seen);
      cmd_valid = 1'b1; cmd_op = op; cmd_row = row; cmd_data = data;
      @(posedge clock); #1;
      cmd_valid  = 1'b0;
      lat        = 0;
      start_seen = mult_start;
      while (rsp_valid !== 1'b1 && lat < 300) begin
         mult_done = (lat == done_at);
         mult_c    = c;
         @(posedge clock); #1;
         lat++;
      end
      mult_done = 1'b0;
      check_bit("rsp_arrived", lat < 300, 1'b1);
      err = rsp_error;
      rd  = rsp_data;
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic [199:0] c_a, c_b, all_ff;
      logic [39:0]  rd, held_data;
      logic         err, start_seen, held_err, stable;
      int           lat;

      c_a    = {25{8'h0A}};
      all_ff = {25{8'hFF}};
      for (int r = 0; r < 5; r++) c_b[r*40 +: 40] = 40'h1111111111 * 40'(r + 1);

      for (int i = 0; i < 5; i++) begin
         vecs[i]     = mk(LA, 3'(i), {5{8'h01}}, -1, '0, 1'b0, 40'h0, 1);
         vecs[i + 5] = mk(LB, 3'(i), {5{8'h02}}, -1, '0, 1'b0, 40'h0, 1);
      end
      vecs[10] = mk(MU, 3'd0, 40'h0, 5, c_a, 1'b0, 40'h0, 6);
      vecs[11] = mk(RC, 3'd3, 40'h0, -1, '0, 1'b0, 40'h0A0A0A0A0A, 1);
      vecs[12] = mk(RC, 3'd7, 40'h0, -1, '0, 1'b1, 40'h0, 1);
      vecs[13] = mk(LB, 3'd0, {5{8'h02}}, -1, '0, 1'b0, 40'h0, 1);
      vecs[14] = mk(RC, 3'd0, 40'h0, -1, '0, 1'b1, 40'h0, 1);
      vecs[15] = mk(MU, 3'd6, 40'h0, 1, c_b, 1'b0, 40'h0, 2);
      vecs[16] = mk(RC, 3'd4, 40'h0, -1, '0, 1'b0, 40'h5555555555, 1);
      vecs[17] = mk(RC, 3'd0, 40'h0, -1, '0, 1'b0, 40'h1111111111, 1);
      vecs[18] = mk(MU, 3'd0, 40'h0, 0, c_a, 1'b1, 40'h0, 1 + TMO);
      vecs[19] = mk(RC, 3'd1, 40'h0, -1, '0, 1'b1, 40'h0, 1);

      reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_row = '0; cmd_data = '0;
      rsp_ready = 1'b0; mult_done = 1'b0; mult_c = '0;
      repeat (3) @(posedge clock);
      #1;
      check_bit("reset_cmd_ready", cmd_ready, 1'b1);
      check_bit("reset_rsp_valid", rsp_valid, 1'b0);
      check_bit("reset_mult_start", mult_start, 1'b0);
      check_vec("reset_matriz_a", matriz_a, '0);
      reset_n = 1'b1;
      @(posedge clock); #1;
      check_vec("reset_rsp_data", 200'(rsp_data), '0);
      check_bit("reset_rsp_error", rsp_error, 1'b0);
      check_vec("reset_matriz_b", matriz_b, '0);

      run_cmd(RC, 3'd0, 40'h0, -1, '0, err, rd, lat, start_seen);
      check_bit("readc_after_reset_err", err, 1'b1);
      check_vec("readc_after_reset_data", 200'(rd), '0);

      for (int i = 0; i < 20; i++) begin
         run_cmd(vecs[i].op, vecs[i].row, vecs[i].data, vecs[i].done_at, vecs[i].c,
                 err, rd, lat, start_seen);
         check_bit($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
         check_vec($sformatf("vec%0d_data", i), 200'(rd), 200'(vecs[i].exp_rd));
         check_int($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
         check_bit($sformatf("vec%0d_start", i), start_seen, vecs[i].op == MU);
      end
      check_vec("matriz_a_loaded", matriz_a, {25{8'h01}});
      check_vec("matriz_b_loaded", matriz_b, {25{8'h02}});
      check_int("start_pulses_table", start_cnt, 3);

      run_cmd(LA, 3'd5, 40'hFFFFFFFFFF, -1, '0, err, rd, lat, start_seen);
      check_bit("load_row5_err", err, 1'b1);
      check_vec("load_row5_data", 200'(rd), '0);
      check_vec("load_row5_a_unchanged", matriz_a, {25{8'h01}});

      run_cmd(MU, 3'd0, 40'h0, 3, c_a, err, rd, lat, start_seen);
      check_bit("mult2_err", err, 1'b0);
      mult_done = 1'b1; mult_c = all_ff;
      @(posedge clock); #1;
      mult_done = 1'b0;
      check_bit("spurious_done_idle", cmd_ready, 1'b1);
      check_bit("spurious_done_no_rsp", rsp_valid, 1'b0);
      run_cmd(RC, 3'd2, 40'h0, -1, '0, err, rd, lat, start_seen);
      check_bit("spurious_readc_err", err, 1'b0);
      check_vec("spurious_readc_data", 200'(rd), 200'(40'h0A0A0A0A0A));

      cmd_valid = 1'b1; cmd_op = RC; cmd_row = 3'd2;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      @(posedge clock); #1;
      check_bit("bp_rsp_valid", rsp_valid, 1'b1);
      held_data = rsp_data;
      held_err  = rsp_error;
      stable    = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cmd_valid = (i % 2 == 0); cmd_op = LA; cmd_row = 3'd0; cmd_data = {5{8'hEE}};
         @(posedge clock); #1;
         if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_data !== held_data || rsp_error !== held_err)
            stable = 1'b0;
      end
      cmd_valid = 1'b0;
      check_bit("bp_held_stable", stable, 1'b1);
      check_vec("bp_held_data", 200'(held_data), 200'(40'h0A0A0A0A0A));
      check_bit("bp_held_err", held_err, 1'b0);
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      check_bit("bp_back_to_idle", cmd_ready, 1'b1);
      check_vec("bp_no_cmd_accepted", matriz_a, {25{8'h01}});

      cmd_valid = 1'b1; cmd_op = MU; cmd_row = 3'd0;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_bit("wait_no_rsp", rsp_valid, 1'b0);
      check_bit("wait_not_ready", cmd_ready, 1'b0);
      reset_n = 1'b0;
      #1;
      check_bit("midreset_cmd_ready", cmd_ready, 1'b1);
      check_bit("midreset_rsp_valid", rsp_valid, 1'b0);
      check_bit("midreset_mult_start", mult_start, 1'b0);
      check_vec("midreset_rsp_data", 200'(rsp_data), '0);
      check_bit("midreset_rsp_error", rsp_error, 1'b0);
      check_vec("midreset_matriz_a", matriz_a, '0);
      check_vec("midreset_matriz_b", matriz_b, '0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
      run_cmd(RC, 3'd2, 40'h0, -1, '0, err, rd, lat, start_seen);
      check_bit("post_reset_readc_err", err, 1'b1);
      check_int("start_pulses_total", start_cnt, 5);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
